// File: rtl/pulse_handshake_pkg.sv
// Shared constants for the toggle-handshake strobe synchronizer.
// Also holds the saturating increment used by the optional drop counter.
package pulse_handshake_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned SYNC_STAGES_MIN     = 2;
    localparam int unsigned SYNC_STAGES_MAX     = 4;
    localparam int unsigned DROP_CNT_W          = 16;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pulse_handshake_sync_bit_sync.sv
// N-stage single-bit synchronizer chain.
// Asynchronous active-high reset clears every stage to 0.
module bit_sync
    import pulse_handshake_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_handshake_sync.sv
// Loss-free single-strobe transfer using a toggle request/acknowledge handshake.
// Optional drop detection (source_drop, drop_count) is enabled by PULSE_HANDSHAKE_DROP_DETECT_EN.
module pulse_handshake_sync
    import pulse_handshake_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  source_strobe,
    output logic                  source_stall,
    input  logic                  dest_stall,
    output logic                  dest_strobe
`ifdef PULSE_HANDSHAKE_DROP_DETECT_EN
    ,
    output logic                  source_drop,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("pulse_handshake_sync: SYNC_STAGES=%0d outside %0d..%0d",
                   SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
        end
    endgenerate

    logic req_toggle_q, req_toggle_d;
    logic req_seen_q,   req_seen_d;
    logic dest_strobe_q, dest_strobe_d;
    logic req_sync;
    logic ack_sync;
    logic accept;
    logic dest_event;
    logic deliver;

    bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_toggle_q),
        .q     (req_sync)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_seen_q),
        .q     (ack_sync)
    );

    // A strobe is in flight from request toggle until its acknowledge returns.
    always_comb begin
        source_stall = req_toggle_q ^ ack_sync;
        accept       = source_strobe & ~source_stall;
        req_toggle_d = req_toggle_q ^ accept;
    end

    always_comb begin
        dest_event    = req_sync ^ req_seen_q;
        deliver       = dest_event & ~dest_stall;
        dest_strobe_d = deliver;
        req_seen_d    = deliver ? req_sync : req_seen_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_toggle_q  <= 1'b0;
            req_seen_q    <= 1'b0;
            dest_strobe_q <= 1'b0;
        end else begin
            req_toggle_q  <= req_toggle_d;
            req_seen_q    <= req_seen_d;
            dest_strobe_q <= dest_strobe_d;
        end
    end

    assign dest_strobe = dest_strobe_q;

`ifdef PULSE_HANDSHAKE_DROP_DETECT_EN
    logic      source_drop_q, source_drop_d;
    drop_cnt_t drop_count_q,  drop_count_d;

    always_comb begin
        source_drop_d = source_strobe & source_stall;
        drop_count_d  = source_drop_d ? sat_inc(drop_count_q) : drop_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            source_drop_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            source_drop_q <= source_drop_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign source_drop = source_drop_q;
    assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_pulse_handshake_sync.sv
// Scoreboard bench: two DUT lanes (SYNC_STAGES=2 and 3) share stimulus; a transaction-level
// model per lane predicts delivery cycles and stall windows. Define PULSE_HANDSHAKE_DROP_DETECT_EN to check drops.
module tb_pulse_handshake_sync;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic source_strobe = 1'b0;
    logic dest_stall = 1'b1;

    logic stall_v  [2];
    logic strobe_v [2];
`ifdef PULSE_HANDSHAKE_DROP_DETECT_EN
    logic        drop_v [2];
    logic [15:0] dcnt_v [2];
`endif

    int checks = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned S = g + 2;

        pulse_handshake_sync #(.SYNC_STAGES(S)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .source_strobe (source_strobe),
            .source_stall  (stall_v[g]),
            .dest_stall    (dest_stall),
            .dest_strobe   (strobe_v[g])
`ifdef PULSE_HANDSHAKE_DROP_DETECT_EN
            ,
            .source_drop   (drop_v[g]),
            .drop_count    (dcnt_v[g])
`endif
        );

        // Transaction-level reference: one strobe in flight, delivered at the first
        // un-stalled edge at least S+1 edges after acceptance, released S edges later.
        int unsigned cyc = 0;
        int unsigned ready_at = 0;
        int unsigned release_at = 0;
        int unsigned drops = 0;
        int unsigned accepted = 0;
        int unsigned lost = 0;
        int unsigned seen = 0;
        bit busy = 0;
        bit done = 0;
        bit drop_flag = 0;
        bit stall_pre = 0;
        bit exp_now = 0;
        int unsigned exp_q[$];

        initial forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                if (busy && !done) lost++;
                busy = 0;
                done = 0;
                drop_flag = 0;
                drops = 0;
                exp_q.delete();
            end else begin
                cyc++;
                stall_pre = busy;
                drop_flag = 0;
                if (busy && done && cyc == release_at) busy = 0;
                if (busy && !done && cyc >= ready_at && !dest_stall) begin
                    done = 1;
                    release_at = cyc + S;
                    exp_q.push_back(cyc);
                end
                if (source_strobe) begin
                    if (!stall_pre) begin
                        busy = 1;
                        done = 0;
                        ready_at = cyc + S + 1;
                        accepted++;
                    end else begin
                        drop_flag = 1;
                        if (drops < 65535) drops++;
                    end
                end
            end
        end

        initial forever begin
            @(posedge clk);
            #1;
            chk($sformatf("lane%0d_source_stall", g), stall_v[g], busy);
            exp_now = (exp_q.size() != 0) && (exp_q[0] == cyc) && !reset;
            chk($sformatf("lane%0d_dest_strobe", g), strobe_v[g], exp_now);
            if (strobe_v[g]) seen++;
            if (exp_now) void'(exp_q.pop_front());
`ifdef PULSE_HANDSHAKE_DROP_DETECT_EN
            chk($sformatf("lane%0d_source_drop", g), drop_v[g], drop_flag);
            chk($sformatf("lane%0d_drop_count", g), dcnt_v[g], drops);
`endif
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall0"},  stall_v[0],  0);
        chk({tag, "_strobe0"}, strobe_v[0], 0);
        chk({tag, "_stall1"},  stall_v[1],  0);
        chk({tag, "_strobe1"}, strobe_v[1], 0);
    endtask

    task automatic pulse_strobe();
        source_strobe = 1'b1;
        @(negedge clk);
        source_strobe = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        // Release reset with dest_stall high: must not produce a pulse.
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("after_release");
        dest_stall = 1'b0;

        for (int k = 0; k < 5; k++) begin
            pulse_strobe();
            repeat (9) @(negedge clk);
        end

        source_strobe = 1'b1;
        repeat (30) @(negedge clk);
        source_strobe = 1'b0;
        repeat (12) @(negedge clk);

        pulse_strobe();
        dest_stall = 1'b1;
        repeat (20) @(negedge clk);
        dest_stall = 1'b0;
        repeat (12) @(negedge clk);

        pulse_strobe();
        @(negedge clk);
        pulse_strobe();
        repeat (12) @(negedge clk);

        pulse_strobe();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pulse_strobe();
        repeat (12) @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            source_strobe = ($urandom_range(0, 2) == 0);
            dest_stall    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        source_strobe = 1'b0;
        dest_stall = 1'b0;
        repeat (40) @(negedge clk);

        chk("lane0_pulse_total", g_lane[0].seen, g_lane[0].accepted - g_lane[0].lost);
        chk("lane1_pulse_total", g_lane[1].seen, g_lane[1].accepted - g_lane[1].lost);
        chk("lane0_idle_stall", stall_v[0], 0);
        chk("lane1_idle_stall", stall_v[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_handshake_sync.md
Name: pulse_handshake_sync

Overview:
- Transfers single-cycle strobes from a source-side interface to a destination-side interface using a toggle request/acknowledge handshake.
- Request and acknowledge each pass through multi-flop synchronizer chains; the whole block runs on one clock.
- Used where producer and consumer are decoupled and need a loss-free, one-strobe-in-flight transfer.
- Source is back-pressured via source_stall; destination can hold off delivery via dest_stall.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for request and acknowledge paths; legal range 2..4.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- source_strobe  input  1  one-cycle request to transfer a strobe; accepted only when source_stall=0.
- source_stall  output  1  high while a strobe is in flight; source must not strobe.
- dest_stall  input  1  destination not ready; delivery is held off while high.
- dest_strobe  output  1  one-cycle pulse; one per accepted source strobe.

Behaviour:
- Reset (async assert, sync-release safe): req_toggle, req sync chain, req_seen, ack sync chain and dest_strobe all 0. source_stall=0 and dest_strobe=0 during and after reset.
- Source side: source_stall = req_toggle XOR ack_sync (last ack stage), combinational from flops.
- Source acceptance: at edge E0 with source_strobe=1 and source_stall=0, req_toggle flips.
- Source ignore rule: source_strobe while source_stall=1 is ignored (dropped, no state change).
- Request path: req_toggle passes through SYNC_STAGES flops to give req_sync.
- Dest event: event = req_sync XOR req_seen.
- Dest delivery: on an edge with event=1 and dest_stall=0, dest_strobe<=1 and req_seen<=req_sync. On all other edges dest_strobe<=0. dest_strobe is never high two consecutive cycles.
- Dest hold: while dest_stall=1, the event stays pending and no pulse is issued; delivery occurs on the first edge with dest_stall=0.
- Ack path: req_seen passes through SYNC_STAGES flops to give ack_sync.
- Latency, no dest_stall, S=SYNC_STAGES:
  - dest_strobe is registered at E0+S+1.
  - source_stall is high for 2S+1 cycles after acceptance.
  - Next strobe is accepted at edge E0+2S+2; maximum rate is 1 strobe per 2S+2 cycles (6 for S=2).
- dest_stall at reset release: no effect; no spurious pulse.
- Simultaneous source_strobe and ack return on the same edge: not accepted, because source_stall is still high in that cycle.
- Reset mid-transfer: in-flight strobe is discarded, never delivered; source_stall drops immediately.

Optional Feature:
- Macro: PULSE_HANDSHAKE_DROP_DETECT_EN.
- With the macro defined:
  - Extra output source_drop (1 bit, registered, reset 0).
  - source_drop pulses one cycle after any source_strobe sampled while source_stall=1.
  - Extra output drop_count (16 bits), saturating, reset 0, counting such drops.
- Without the macro: neither port exists; ignored strobes are silent.

Decomposition:
- Package pulse_handshake_pkg holds:
  - constants SYNC_STAGES_DEFAULT=2, SYNC_STAGES_MIN=2, SYNC_STAGES_MAX=4;
  - DROP_CNT_W=16.
- Sub-module bit_sync: N-stage single-bit synchronizer with async active-high reset to 0. It is instantiated twice (request and acknowledge paths).
- Elaboration check: SYNC_STAGES within range.

Test Plan:
- Reset then 5 isolated source_strobes spaced 10 cycles, dest_stall=0, S=2 -> exactly 5 dest_strobe pulses, each 3 cycles after its acceptance edge; source_stall high 5 cycles per strobe.
- source_strobe held high continuously for 30 cycles -> one acceptance every 6 cycles (5 accepted), 5 dest_strobes, no back-to-back dest_strobe.
- One strobe accepted, dest_stall held high 20 cycles -> no dest_strobe and source_stall high throughout. dest_stall drops -> dest_strobe one cycle later, then source_stall low 2 cycles after that.
- Strobe while source_stall=1 -> ignored; total dest_strobe count unchanged. With PULSE_HANDSHAKE_DROP_DETECT_EN: source_drop pulses once and drop_count=1.
- Assert reset 2 cycles after acceptance -> source_stall=0 and dest_strobe=0 immediately. No dest_strobe ever appears for that strobe; a subsequent strobe is delivered normally.
- SYNC_STAGES=3 -> dest_strobe 4 cycles after acceptance; source_stall high 7 cycles.
